ysyx_24070016_lsu: RTL
======================

# ysyx_24070016_lsu

Load/store unit sitting directly upstream of the data-memory port. It accepts one load or store per transaction from the execute stage over a valid/ready handshake and issues it as a single word-aligned request with byte strobes on a split request/response memory channel. Returned read data is lane-shifted and sign- or zero-extended before being handed to writeback over a second valid/ready handshake. The unit holds at most one transaction at a time and never issues a new one until the previous one has been consumed.

## Interface
- TAG_W, 5: width of the pass-through tag (destination register index).
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request from EXU.
- in_ready  out  1  LSU can accept a request.
- in_wren  in  1  1 = store, 0 = load.
- in_op  in  3  access type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010).
- in_addr  in  32  byte address.
- in_wdata  in  32  store data, right-aligned.
- in_tag  in  TAG_W  passed through unchanged.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wren  out  1  store request.
- mem_req_addr  out  32  word address, bits [1:0] = 0.
- mem_req_wdata  out  32  lane-positioned store data.
- mem_req_wstrb  out  4  byte strobes; zero for loads.
- mem_resp_valid  in  1  response valid.
- mem_resp_ready  out  1  LSU accepts the response.
- mem_resp_rdata  in  32  raw word read data.
- mem_resp_err  in  1  bus error.
- out_valid  out  1  result for WBU.
- out_ready  in  1  WBU accepts the result.
- out_rdata  out  32  extended load data; 0 for stores and errors.
- out_tag  out  TAG_W  latched in_tag.
- out_err  out  1  bus, op or alignment error.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, latch wren, op, addr, wdata and tag, then go to REQ. If op is illegal (011, 11x, or a store with op[2]=1), go directly to DONE with err=1 and issue no memory access.
- REQ: mem_req_valid=1, with request fields stable. On mem_req_ready, go to WAIT.
- WAIT: mem_resp_ready=1. On mem_resp_valid, capture the extended data and mem_resp_err, then go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE.
- Store lanes:
  - sb: wdata[7:0] replicated to all four lanes; wstrb = 0001 << addr[1:0].
  - sh: wdata[15:0] replicated to both halves; wstrb = 0011 << {addr[1],0}.
  - sw: wstrb = 1111.
- Load: shift the raw word right by 8*addr[1:0] (addr[1] only for halfword; no shift for word), then sign- or zero-extend per op[2].
- Loads and stores both complete through DONE. Stores return out_rdata=0.
- If mem_resp_err=1, out_rdata=0 and out_err=1.

## Timing
- Reset: state=IDLE, in_ready=1. Every other output is 0, including the registered out_* fields.
- Reset is asynchronous and may occur in any state. The transaction is abandoned and the FSM returns to IDLE. A memory response arriving after reset, while in IDLE or REQ, is not accepted (mem_resp_ready=0).
- Minimum latency with memory ready and responding immediately: accept at cycle 0, request at cycle 1, response at cycle 2, out_valid at cycle 3.
- Handshakes complete on valid&ready at a rising edge. Once asserted, valid outputs stay high and their fields stay stable until accepted.
- in_ready is combinational from state only. It never depends on in_valid.
- Back-pressure (out_ready=0) holds DONE indefinitely. No new request is accepted during that time.

## Configuration
- YSYX_24070016_LSU_ALIGN_CHECK_EN defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, goes IDLE→DONE with out_err=1 and no memory access.
- Macro undefined: misaligned addresses are truncated to natural alignment (halfword: addr[0] cleared; word: addr[1:0] cleared) and the access proceeds normally.

## Structure
- Shared package ysyx_24070016_pkg holds:
  - mem_op localparams (OP_LB/LH/LW/LBU/LHU);
  - the LSU state enum;
  - strobe width constant 4.
- One combinational sub-module, ysyx_24070016_lsu_align, contains the store lane/strobe generation and the load shift/extend. The FSM and registers stay in the top.

## Test plan
- sb addr=0x80000003 wdata=0x000000AB → wstrb=1000, mem_req_addr=0x80000000, mem_req_wdata=0xABABABAB, out_rdata=0.
- lh addr=0x80000002, raw word 0x8001_1234 → out_rdata=0xFFFF8001; lhu on the same word → 0x00008001.
- lb addr=0x80000001, raw 0x0000F000 → 0xFFFFFFF0; mem_req_ready delayed 3 cycles → out_valid exactly 2 cycles after the request is accepted.
- lw with mem_resp_err=1 → out_err=1, out_rdata=0; out_ready held 0 for 4 cycles → out_valid and fields stable, in_ready=0 throughout.
- lw addr=0x80000002 → with the macro: out_err=1 and no mem_req_valid pulse; without the macro: mem_req_addr=0x80000000 and a normal load.
- rst_n low during WAIT → all outputs 0 and in_ready=1 immediately; a later mem_resp_valid is ignored, and the next lw completes correctly.

Source files
------------

// File: rtl/ysyx_24070016_pkg.sv
// Shared definitions for the load/store unit: memory op encodings,
// FSM state type, strobe width and op legality helpers.
// The misalignment helper is used only when YSYX_24070016_LSU_ALIGN_CHECK_EN
// is defined.
package ysyx_24070016_pkg;

  localparam int STRB_W = 4;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Encodings 011, 110 and 111 do not exist; stores have no unsigned form.
  function automatic logic illegal_op(input logic wren, input logic [2:0] op);
    return (op[1:0] == 2'b11) || (op[2:1] == 2'b11) || (wren && op[2]);
  endfunction

  // Halfword must sit on an even address, word on a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    return ((op[1:0] == 2'b01) && lo[0]) || ((op[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_24070016_lsu_align.sv
// Pure combinational lane logic for the LSU: places store data and byte
// strobes on the correct lanes of the word bus, and pulls load data off the
// correct lane with sign/zero extension. Misaligned halfword/word addresses
// are handled by natural truncation here; rejecting them is done in the top
// when YSYX_24070016_LSU_ALIGN_CHECK_EN is defined.
module ysyx_24070016_lsu_align
  import ysyx_24070016_pkg::*;
(
  input  logic              wren,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic [31:0]       req_addr,
  output logic [31:0]       req_wdata,
  output logic [STRB_W-1:0] req_wstrb,
  output logic [31:0]       load_data
);

  logic [31:0] shifted;

  assign req_addr = {addr[31:2], 2'b00};

  // Store lane replication and strobes; loads never assert strobes.
  always_comb begin
    req_wdata = wdata;
    req_wstrb = '0;
    if (wren) begin
      case (op[1:0])
        2'b00: begin
          req_wdata = {4{wdata[7:0]}};
          req_wstrb = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          req_wdata = {2{wdata[15:0]}};
          req_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        end
        default: req_wstrb = 4'b1111;
      endcase
    end
  end

  // Load lane extraction followed by sign/zero extension (op[2] = unsigned).
  always_comb begin
    case (op[1:0])
      2'b00:   shifted = rdata >> {addr[1:0], 3'b000};
      2'b01:   shifted = rdata >> {addr[1], 4'b0000};
      default: shifted = rdata;
    endcase
    case (op[1:0])
      2'b00:   load_data = op[2] ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = op[2] ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_24070016_lsu.sv
// Load/store unit: one transaction in flight, IDLE -> REQ -> WAIT -> DONE.
// Illegal ops (and, with YSYX_24070016_LSU_ALIGN_CHECK_EN defined, misaligned
// halfword/word accesses) skip the memory and go straight to DONE with
// out_err set.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid driven by this unit stays high with stable fields until
// accepted; in_ready depends only on state.
module ysyx_24070016_lsu
  import ysyx_24070016_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wren,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_wren,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_wdata,
  output logic [3:0]       mem_req_wstrb,
  input  logic             mem_resp_valid,
  output logic             mem_resp_ready,
  input  logic [31:0]      mem_resp_rdata,
  input  logic             mem_resp_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rdata,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  lsu_state_e       state, state_nxt;
  logic             wren_q;
  logic [2:0]       op_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             early_err;
  logic             misalign;
  logic             in_fire;
  logic             resp_fire;
  logic [31:0]      load_data;

`ifdef YSYX_24070016_LSU_ALIGN_CHECK_EN
  assign misalign = is_misaligned(in_op, in_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign early_err = illegal_op(in_wren, in_op) || misalign;
  assign in_fire   = in_valid && in_ready;
  assign resp_fire = mem_resp_valid && mem_resp_ready;

  ysyx_24070016_lsu_align u_align (
    .wren      (wren_q),
    .op        (op_q),
    .addr      (addr_q),
    .wdata     (wdata_q),
    .rdata     (mem_resp_rdata),
    .req_addr  (mem_req_addr),
    .req_wdata (mem_req_wdata),
    .req_wstrb (mem_req_wstrb),
    .load_data (load_data)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs, all decoded from state.
  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    out_valid      = 1'b0;
    case (state)
      LSU_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = early_err ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = LSU_WAIT;
      end
      LSU_WAIT: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) state_nxt = LSU_DONE;
      end
      LSU_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = LSU_IDLE;
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  // Transaction registers: latched on accept, result captured on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren_q  <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (in_fire) begin
        wren_q  <= in_wren;
        op_q    <= in_op;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        tag_q   <= in_tag;
        rdata_q <= '0;
        err_q   <= early_err;
      end
      if (resp_fire) begin
        rdata_q <= (wren_q || mem_resp_err) ? '0 : load_data;
        err_q   <= mem_resp_err;
      end
    end
  end

  assign mem_req_wren = wren_q;
  assign out_rdata    = rdata_q;
  assign out_tag      = tag_q;
  assign out_err      = err_q;

endmodule
